// File: rtl/inst_queue.sv
// Fetch-to-decode instruction queue: compacts up to IN_W fetched (PC, IR) pairs per cycle
// into a circular buffer and presents the OUT_W oldest entries to decode.
module inst_queue #(
   parameter int DEPTH  = 16,
   parameter int IN_W   = 2,
   parameter int OUT_W  = 2,
   parameter int DATA_W = 32
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic [IN_W-1:0][DATA_W-1:0]    i_PC,
   input  logic [IN_W-1:0][DATA_W-1:0]    i_IR,
   input  logic [IN_W-1:0]                i_is_valid,
   input  logic                           flush_BR,
   input  logic [$clog2(OUT_W+1)-1:0]     i_usingNUM,
   output logic [OUT_W-1:0][DATA_W-1:0]   o_PC,
   output logic [OUT_W-1:0][DATA_W-1:0]   o_IR,
   output logic [OUT_W-1:0]               o_is_valid,
   output logic [$clog2(DEPTH+1)-1:0]     o_count,
   output logic                           o_is_full
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam int CNT_W = $clog2(DEPTH+1);

   logic [DATA_W-1:0] r_pc_mem [DEPTH];
   logic [DATA_W-1:0] r_ir_mem [DEPTH];
   logic [PTR_W-1:0]  r_head;
   logic [PTR_W-1:0]  r_tail;
   logic [CNT_W-1:0]  r_count;

   logic [PTR_W-1:0]  w_offset [IN_W];
   logic [CNT_W-1:0]  w_n_in;
   logic [CNT_W-1:0]  w_n_out;
   logic [CNT_W-1:0]  w_free;
   logic              w_push_ok;

   // Each valid slot lands at tail plus the number of valid slots below it.
   // NOTE: blocking assignments here build a running sum within one evaluation.
   always_comb begin
      w_n_in = '0;
      for (int i = 0; i < IN_W; i++) begin
         w_offset[i] = w_n_in[PTR_W-1:0];
         w_n_in      = w_n_in + CNT_W'(i_is_valid[i]);
      end
   end

   always_comb begin
      w_n_out = CNT_W'(i_usingNUM);
      if (r_count < w_n_out)
         w_n_out = r_count;
      if (CNT_W'(OUT_W) < w_n_out)
         w_n_out = CNT_W'(OUT_W);
   end

   assign w_free    = CNT_W'(DEPTH) - r_count;
   assign o_is_full = (w_free < CNT_W'(IN_W));
   assign w_push_ok = !flush_BR && !o_is_full;
   assign o_count   = r_count;

   // NOTE: control state takes non-blocking updates so every reader sees pre-edge values.
   always_ff @(posedge clk) begin
      if (rst || flush_BR) begin
         r_head  <= '0;
         r_tail  <= '0;
         r_count <= '0;
      end else begin
         r_head <= r_head + w_n_out[PTR_W-1:0];
         if (w_push_ok) begin
            r_tail  <= r_tail + w_n_in[PTR_W-1:0];
            r_count <= r_count + w_n_in - w_n_out;
         end else begin
            r_count <= r_count - w_n_out;
         end
      end
   end

   // NOTE: storage has no reset; entries are only observable once counted as occupied.
   always_ff @(posedge clk) begin
      if (w_push_ok) begin
         for (int i = 0; i < IN_W; i++) begin
            if (i_is_valid[i]) begin
               r_pc_mem[r_tail + w_offset[i]] <= i_PC[i];
               r_ir_mem[r_tail + w_offset[i]] <= i_IR[i];
            end
         end
      end
   end

   for (genvar k = 0; k < OUT_W; k++) begin : g_out
      logic [PTR_W-1:0] w_rd_idx;
      assign w_rd_idx      = r_head + PTR_W'(k);
      assign o_is_valid[k] = (CNT_W'(k) < r_count);
      assign o_PC[k]       = o_is_valid[k] ? r_pc_mem[w_rd_idx] : '0;
      assign o_IR[k]       = o_is_valid[k] ? r_ir_mem[w_rd_idx] : '0;
   end

endmodule

// File: tb/tb_inst_queue.sv
// Randomised and directed bench for inst_queue; a queue-based model is compared to the DUT every cycle.
module tb_inst_queue;

   localparam int DEPTH  = 8;
   localparam int IN_W   = 2;
   localparam int OUT_W  = 2;
   localparam int DATA_W = 32;
   localparam int USE_W  = $clog2(OUT_W+1);
   localparam int CNT_W  = $clog2(DEPTH+1);

   typedef struct {
      logic [DATA_W-1:0] pc;
      logic [DATA_W-1:0] ir;
   } ent_t;

   logic                          clk = 1'b0;
   logic                          rst = 1'b1;
   logic [IN_W-1:0][DATA_W-1:0]   i_PC = '0;
   logic [IN_W-1:0][DATA_W-1:0]   i_IR = '0;
   logic [IN_W-1:0]               i_is_valid = '0;
   logic                          flush_BR = 1'b0;
   logic [USE_W-1:0]              i_usingNUM = '0;
   logic [OUT_W-1:0][DATA_W-1:0]  o_PC;
   logic [OUT_W-1:0][DATA_W-1:0]  o_IR;
   logic [OUT_W-1:0]              o_is_valid;
   logic [CNT_W-1:0]              o_count;
   logic                          o_is_full;

   int   n_checks = 0;
   int   n_errors = 0;
   bit   cmp_en   = 1'b0;
   ent_t model_q[$];
   logic [DATA_W-1:0] dut_drained[$];

   inst_queue #(.DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .DATA_W(DATA_W)) dut (
      .clk(clk), .rst(rst), .i_PC(i_PC), .i_IR(i_IR), .i_is_valid(i_is_valid),
      .flush_BR(flush_BR), .i_usingNUM(i_usingNUM), .o_PC(o_PC), .o_IR(o_IR),
      .o_is_valid(o_is_valid), .o_count(o_count), .o_is_full(o_is_full)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // Every cycle: outputs must show the oldest model entries, zero beyond occupancy.
   always @(negedge clk) begin
      if (cmp_en) begin
         check("count", 64'(o_count), 64'(model_q.size()));
         check("full", 64'(o_is_full), 64'((DEPTH - model_q.size()) < IN_W));
         for (int k = 0; k < OUT_W; k++) begin
            check($sformatf("valid[%0d]", k), 64'(o_is_valid[k]), 64'(k < model_q.size()));
            check($sformatf("pc[%0d]", k), 64'(o_PC[k]), (k < model_q.size()) ? 64'(model_q[k].pc) : 64'd0);
            check($sformatf("ir[%0d]", k), 64'(o_IR[k]), (k < model_q.size()) ? 64'(model_q[k].ir) : 64'd0);
         end
      end
   end

   // Drive one cycle (called just after a falling edge), apply it to the model at the
   // rising edge, and return at the next falling edge with outputs settled.
   task automatic cycle(input logic [IN_W-1:0][DATA_W-1:0] pcs, input logic [IN_W-1:0] vld,
                        input int use_n, input bit fl);
      int n_out;
      bit full;
      i_PC       = pcs;
      i_IR       = ~pcs;
      i_is_valid = vld;
      i_usingNUM = USE_W'(use_n);
      flush_BR   = fl;
      n_out = use_n;
      if (n_out > int'(o_count)) n_out = int'(o_count);
      if (n_out > OUT_W) n_out = OUT_W;
      if (!rst && !fl)
         for (int k = 0; k < n_out; k++) dut_drained.push_back(o_PC[k]);
      @(posedge clk);
      if (rst || fl) begin
         model_q.delete();
      end else begin
         full  = (DEPTH - model_q.size()) < IN_W;
         n_out = use_n;
         if (n_out > model_q.size()) n_out = model_q.size();
         if (n_out > OUT_W) n_out = OUT_W;
         repeat (n_out) void'(model_q.pop_front());
         if (!full)
            for (int i = 0; i < IN_W; i++)
               if (vld[i]) model_q.push_back('{pc: pcs[i], ir: ~pcs[i]});
      end
      @(negedge clk);
   endtask

   task automatic push2(input logic [DATA_W-1:0] pc_lo, input int use_n);
      cycle({pc_lo + 32'd4, pc_lo}, 2'b11, use_n, 1'b0);
   endtask

   task automatic idle(input int use_n, input bit fl);
      cycle('0, 2'b00, use_n, fl);
   endtask

   initial begin
      logic [DATA_W-1:0] base;
      @(negedge clk);
      rst = 1'b1;
      idle(0, 0);
      idle(0, 0);
      rst = 1'b0;
      cmp_en = 1'b1;
      check("reset count", 64'(o_count), 64'd0);
      check("reset valid", 64'(o_is_valid), 64'd0);
      check("reset full", 64'(o_is_full), 64'd0);
      check("reset pc0", 64'(o_PC[0]), 64'd0);

      // Basic push
      push2(32'h1c000000, 0);
      check("basic valid", 64'(o_is_valid), 64'b11);
      check("basic pc0", 64'(o_PC[0]), 64'h1c000000);
      check("basic pc1", 64'(o_PC[1]), 64'h1c000004);
      check("basic count", 64'(o_count), 64'd2);
      idle(0, 1);

      // Sparse mask: only slot 1 valid
      cycle({32'h1c000104, 32'h1c000100}, 2'b10, 0, 1'b0);
      check("sparse valid", 64'(o_is_valid), 64'b01);
      check("sparse pc0", 64'(o_PC[0]), 64'h1c000104);
      check("sparse count", 64'(o_count), 64'd1);
      idle(0, 1);

      // Full and drop
      base = 32'h1c000200;
      for (int c = 0; c < 3; c++) push2(base + 32'(8*c), 0);
      check("fill6 count", 64'(o_count), 64'd6);
      check("fill6 full", 64'(o_is_full), 64'd0);
      push2(base + 32'd24, 0);
      check("fill8 count", 64'(o_count), 64'd8);
      check("fill8 full", 64'(o_is_full), 64'd1);
      push2(32'h1c0000f0, 0);
      check("drop count", 64'(o_count), 64'd8);
      dut_drained.delete();
      for (int c = 0; c < 4; c++) idle(2, 0);
      check("drop drained n", 64'(dut_drained.size()), 64'd8);
      foreach (dut_drained[i]) begin
         check("drop no f0", 64'(dut_drained[i] == 32'h1c0000f0), 64'd0);
         check("drop order", 64'(dut_drained[i]), 64'(base + 32'(4*i)));
      end

      // Simultaneous push and pop at count 6
      base = 32'h1c000300;
      dut_drained.delete();
      for (int c = 0; c < 3; c++) push2(base + 32'(8*c), 0);
      push2(base + 32'd24, 2);
      check("simul count", 64'(o_count), 64'd6);
      check("simul pc0", 64'(o_PC[0]), 64'(base + 32'd8));
      for (int c = 0; c < 3; c++) idle(2, 0);
      check("simul drained n", 64'(dut_drained.size()), 64'd8);
      foreach (dut_drained[i]) check("simul order", 64'(dut_drained[i]), 64'(base + 32'(4*i)));

      // Flush priority at count 5
      push2(32'h1c000400, 0);
      push2(32'h1c000408, 0);
      cycle({32'h0, 32'h1c000410}, 2'b01, 0, 1'b0);
      check("pre-flush count", 64'(o_count), 64'd5);
      cycle({32'h1c000418, 32'h1c000414}, 2'b11, 2, 1'b1);
      check("flush count", 64'(o_count), 64'd0);
      check("flush valid", 64'(o_is_valid), 64'b00);
      push2(32'h1c000500, 0);
      check("post-flush count", 64'(o_count), 64'd2);
      check("post-flush pc0", 64'(o_PC[0]), 64'h1c000500);
      idle(0, 1);

      // Wrap: stream 40 sequential PCs, then over-pop
      dut_drained.delete();
      for (int c = 0; c < 20; c++) push2(32'h1c000000 + 32'(8*c), 2);
      idle(2, 0);
      check("wrap drained n", 64'(dut_drained.size()), 64'd40);
      foreach (dut_drained[i]) check("wrap order", 64'(dut_drained[i]), 64'(32'h1c000000 + 32'(4*i)));
      cycle({32'h0, 32'h1c000600}, 2'b01, 0, 1'b0);
      check("overpop pre", 64'(o_count), 64'd1);
      idle(2, 0);
      check("overpop count", 64'(o_count), 64'd0);
      check("overpop valid", 64'(o_is_valid), 64'b00);

      // Random traffic
      for (int c = 0; c < 3000; c++) begin
         rst = ($urandom_range(0, 199) == 0);
         cycle({$urandom(), $urandom()}, IN_W'($urandom_range(0, 3)),
               int'($urandom_range(0, OUT_W)), ($urandom_range(0, 15) == 0));
      end
      rst = 1'b0;
      idle(0, 0);

      cmp_en = 1'b0;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule

// File: doc/inst_queue.md
# inst_queue

Parametrised fetch-to-decode instruction queue that buffers up to IN_W fetched (PC, IR) pairs per cycle and presents up to OUT_W oldest entries per cycle to decode. It replaces the fixed two-wide IF2/ID1 buffer with configurable depth, fetch width and decode width. It accepts sparse fetch masks, partial consumption by decode, and branch flush. The full flag drives the fetch-stage stall (stall_full_instr).

## Interface
- DEPTH, 16: number of entries; power of two, >= 2*max(IN_W, OUT_W).
- IN_W, 2: fetch slots pushed per cycle.
- OUT_W, 2: decode slots presented per cycle.
- DATA_W, 32: PC and IR width.
- clk  input  1  single clock; all state changes on rising edge.
- rst  input  1  synchronous, active-high reset.
- i_PC  input  IN_W x DATA_W  fetch PCs; slot 0 is program-order oldest.
- i_IR  input  IN_W x DATA_W  fetch instruction words.
- i_is_valid  input  IN_W  per-slot valid mask; any pattern allowed.
- flush_BR  input  1  branch mispredict; discard all contents.
- i_usingNUM  input  $clog2(OUT_W+1)  entries consumed by decode this cycle.
- o_PC  output  OUT_W x DATA_W  head entries; slot 0 oldest.
- o_IR  output  OUT_W x DATA_W  head instruction words.
- o_is_valid  output  OUT_W  contiguous-from-slot-0 valid mask.
- o_count  output  $clog2(DEPTH+1)  current occupancy.
- o_is_full  output  1  free slots < IN_W; fetch must stall.

## Operation
- State: storage array of DEPTH x (PC, IR), head pointer, tail pointer ($clog2(DEPTH) bits each, wrap modulo DEPTH), and occupancy counter.
- Push:
  - Let n_in = popcount(i_is_valid).
  - The push is accepted iff !flush_BR and !o_is_full.
  - Valid slots are compacted in slot order: the lowest-index valid slot is written at tail, the next at tail+1, and so on.
  - Tail advances by n_in.
  - A rejected push is dropped silently. The upstream stage is responsible for holding the push using o_is_full.
- Pop:
  - n_out = min(i_usingNUM, count, OUT_W).
  - Head advances by n_out.
  - Requests beyond occupancy are clamped, not errors.
- Output slot k:
  - o_is_valid[k] = (k < count).
  - o_PC[k] and o_IR[k] = storage[head+k] when valid, else 0.
- Occupancy update: count_next = count + n_in_accepted - n_out. This covers a simultaneous push and pop in the same cycle.
- Flush: head, tail and count go to 0. Any same-cycle push and pop are ignored. Flush takes priority over everything except rst.
- Reset (rst=1 at edge): head, tail and count go to 0. Storage is not reset.
- Reset values of outputs: o_is_valid=0, o_PC=0, o_IR=0, o_count=0, o_is_full=0.

## Timing
- Outputs are combinational from registered head, count and storage only. There is no combinational path from the i_* inputs or flush_BR to any output.
- Push latency: an entry pushed at edge t is visible on o_* after edge t, i.e. in cycle t+1.
- Pop takes effect at the edge: decode samples o_* in cycle t, asserts i_usingNUM in cycle t, and the new head is seen in cycle t+1.
- o_is_full is derived from registered count. A pop in the same cycle does not relieve a full condition until the next cycle, so fullness is conservative.
- Flush at edge t: o_is_valid=0 in cycle t+1. A push in cycle t+1 is accepted normally.
- Pointer wrap-around is invisible to ordering; slots in o_* always follow program order.
- Throughput: sustains min(IN_W, OUT_W) instructions per cycle indefinitely with no bubbles.

## Test plan
All scenarios use DEPTH=8, IN_W=2, OUT_W=2.
- Basic push: release rst, then push PC 0x1c000000/0x1c000004, valid=2'b11, usingNUM=0. Next cycle: o_is_valid=2'b11, o_PC[0]=0x1c000000, o_PC[1]=0x1c000004, o_count=2.
- Sparse mask: push valid=2'b10 with i_PC[1]=0x1c000104 into an empty queue. Next cycle: o_is_valid=2'b01, o_PC[0]=0x1c000104, o_count=1.
- Full and drop:
  - Push 2 per cycle for 3 cycles; o_count=6, o_is_full=0.
  - A 4th push makes o_count=8 with o_is_full=1.
  - A 5th push of 0x1c0000f0/f4 is dropped, and o_count stays 8.
  - Popping all 8 entries shows no 0x1c0000f0.
- Simultaneous push and pop: at count=6, push 2 and usingNUM=2. Next cycle o_count=6, o_PC[0] is the 3rd-oldest PC, and order is preserved through a full drain.
- Flush priority: at count=5, assert flush_BR with valid=2'b11 and usingNUM=2. Next cycle o_count=0, o_is_valid=2'b00. The following push is seen normally.
- Wrap and over-pop:
  - Stream 40 sequential PCs (push 2, pop 2 per cycle). Output order is exactly 0x1c000000 + 4*i.
  - Then at count=1 with usingNUM=2, the next o_count=0 with no underflow.
